// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: redirect request, synchronous instruction-memory read port and decode handshake.
// master is the fetch queue itself; slave is the surrounding pipeline/memory.
interface instr_fetch_queue_if #(
    parameter int size = 32
);
    logic            redirect;
    logic [size-1:0] redirect_pc;
    logic            imem_en;
    logic [size-1:0] imem_addr;
    logic [size-1:0] imem_data;
    logic            out_valid;
    logic            out_ready;
    logic [size-1:0] out_instr;
    logic [size-1:0] out_pc;
    logic [size-1:0] out_pc_4;
    logic [3:0]      count;

    modport master (
        input  redirect, redirect_pc, imem_data, out_ready,
        output imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_4, count
    );

    modport slave (
        output redirect, redirect_pc, imem_data, out_ready,
        input  imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_4, count
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: credit-based reads from a 1-cycle synchronous memory into a DEPTH-entry FIFO.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_flushed counters.
module instr_fetch_queue #(
    parameter int size  = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]         perf_fetched,
    output logic [15:0]         perf_flushed
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t           r_state;
    logic [size-1:0]  r_fetch_pc;
    logic             r_inflight;
    logic [size-1:0]  r_issue_pc;
    logic [3:0]       r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [size-1:0]  r_instr_q [DEPTH];
    logic [size-1:0]  r_pc_q    [DEPTH];

    logic w_credit;
    logic w_issue;
    logic w_push;
    logic w_pop;

    // An in-flight read already owns a slot, so issue only while slots remain after it lands.
    assign w_credit = ({1'b0, r_count} + 5'(r_inflight)) < 5'(DEPTH);
    assign w_issue  = (r_state == FETCH) && w_credit && !bus.redirect;
    assign w_pop    = (r_count != 4'd0) && bus.out_ready;
    assign w_push   = r_inflight && !bus.redirect;

    assign bus.imem_en   = w_issue;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.out_valid = (r_count != 4'd0);
    assign bus.out_instr = r_instr_q[r_rd_ptr];
    assign bus.out_pc    = r_pc_q[r_rd_ptr];
    assign bus.out_pc_4  = r_pc_q[r_rd_ptr] + size'(1);
    assign bus.count     = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BOOT;
        end else begin
            case (r_state)
                BOOT:    r_state <= FETCH;
                FETCH:   if (!bus.redirect && !w_credit) r_state <= HOLD;
                HOLD:    if (bus.redirect || w_credit) r_state <= FETCH;
                default: r_state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= '0;
            r_inflight <= 1'b0;
            r_issue_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (bus.redirect) begin
                r_fetch_pc <= bus.redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + size'(1);
                r_issue_pc <= r_fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + 4'(w_push) - 4'(w_pop);
        end
    end

    // NOTE: the storage is reset because the head entry drives out_instr/out_pc directly,
    // and those must read as zero during reset; at DEPTH <= 8 this is a handful of flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_q[i] <= '0;
                r_pc_q[i]    <= '0;
            end
        end else if (w_push) begin
            r_instr_q[r_wr_ptr] <= bus.imem_data;
            r_pc_q[r_wr_ptr]    <= r_issue_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_flushed;
    logic [3:0]  w_flush_n;
    logic [16:0] w_flushed_sum;

    // Entries left after this cycle's handshake, plus the read killed in flight.
    assign w_flush_n     = r_count - 4'(w_pop) + 4'(r_inflight);
    assign w_flushed_sum = {1'b0, r_perf_flushed} + 17'(w_flush_n);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_push && (r_perf_fetched != 16'hFFFF)) r_perf_fetched <= r_perf_fetched + 16'd1;
            if (bus.redirect) r_perf_flushed <= w_flushed_sum[16] ? 16'hFFFF : w_flushed_sum[15:0];
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_queue;
    localparam int SIZE  = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_queue_if #(.size(SIZE)) bus ();

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    instr_fetch_queue #(.size(SIZE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of PCs awaiting decode, plus the single outstanding read.
    logic [31:0] m_q[$];
    bit          m_boot;
    bit          m_can_fetch;
    bit          m_inflight;
    logic [31:0] m_inflight_pc;
    logic [31:0] m_fetch_pc;
    int          m_fetched;
    int          m_flushed;

    // Values seen in the most recent cycle, for directed checks.
    bit          s_en;
    bit          s_valid;
    logic [31:0] s_pc;
    int          s_count;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    function automatic int sat16(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_boot        = 1'b1;
        m_can_fetch   = 1'b0;
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_fetch_pc    = '0;
        m_fetched     = 0;
        m_flushed     = 0;
    endtask

    // Called just after a rising edge; asserts reset between edges and releases it after hold_cycles edges.
    task automatic apply_reset(int hold_cycles);
        #2 reset = 1'b0;
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_imem_en",   bus.imem_en,   0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_count",     bus.count,     0);
        check("rst_imem_addr", bus.imem_addr, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_pc",    bus.out_pc,    0);
        check("rst_out_pc_4",  bus.out_pc_4,  1);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 0);
        check("rst_perf_flushed", perf_flushed, 0);
`endif
        repeat (hold_cycles) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        bus.imem_data = $urandom();
    endtask

    // Drive one cycle's inputs, compare at the falling edge, then advance the model.
    task automatic step(bit rdy, bit redir, logic [31:0] tgt);
        bit          credit;
        bit          exp_en;
        bit          pop;
        logic [31:0] issued;
        bus.out_ready   = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = tgt;
        @(negedge clk);
        credit = (m_q.size() + int'(m_inflight)) < DEPTH;
        exp_en = !m_boot && m_can_fetch && credit && !redir;
        s_en    = bus.imem_en;
        s_valid = bus.out_valid;
        s_pc    = bus.out_pc;
        s_count = int'(bus.count);
        check("imem_en",   bus.imem_en,   exp_en);
        check("imem_addr", bus.imem_addr, m_fetch_pc);
        check("count",     bus.count,     m_q.size());
        check("out_valid", bus.out_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("out_pc",    bus.out_pc,    m_q[0]);
            check("out_pc_4",  bus.out_pc_4,  m_q[0] + 32'd1);
            check("out_instr", bus.out_instr, mem_word(m_q[0]));
        end
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_flushed", perf_flushed, m_flushed);
`endif
        pop    = (m_q.size() > 0) && rdy;
        issued = m_fetch_pc;
        if (redir) begin
            m_flushed = sat16(m_flushed + m_q.size() - int'(pop) + int'(m_inflight));
            m_q.delete();
            m_fetch_pc = tgt;
            m_inflight = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_inflight) begin
                m_q.push_back(m_inflight_pc);
                m_fetched = sat16(m_fetched + 1);
            end
            m_inflight    = exp_en;
            m_inflight_pc = m_fetch_pc;
            if (exp_en) m_fetch_pc = m_fetch_pc + 32'd1;
        end
        // Fetch is allowed in a cycle if the previous one was boot, had credit, or redirected.
        m_can_fetch = m_boot || credit || redir;
        m_boot      = 1'b0;
        @(posedge clk);
        #1;
        bus.imem_data = exp_en ? mem_word(issued) : $urandom();
    endtask

    initial begin
        int          first_en;
        int          first_valid;
        logic [31:0] first_pc;
        bit          saw_stale;
        logic [31:0] wrap_seq[$];

        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b1;
        bus.imem_data   = '0;
        model_reset();
        apply_reset(2);

        // Stream from reset with decode always ready.
        first_en    = -1;
        first_valid = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, '0);
            if (s_en && first_en < 0) first_en = k;
            if (s_valid && first_valid < 0) first_valid = k;
        end
        check("first_imem_en_cycle",   first_en,    1);
        check("first_out_valid_cycle", first_valid, 3);

        // Decode stalls for 10 cycles: queue fills and fetch holds.
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, '0);
        check("stall_count_full", s_count, DEPTH);
        check("stall_imem_en",    s_en,    0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, '0);

        // Redirect to 0x40 with three entries queued and a read in flight.
        apply_reset(1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h40);
        check("redir40_count_before", s_count, 3);
`ifdef FETCH_PERF_EN
        check("redir40_perf_flushed", perf_flushed, 4);
`endif
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, '0);
            if (k < 3) check("redir40_early_valid", s_valid, 0);
        end
        check("redir40_valid_at_3", s_valid, 1);
        check("redir40_pc_at_3",    s_pc,    32'h40);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, '0);

        // Redirect with a handshake, then a second redirect the next cycle.
        step(1'b1, 1'b1, 32'h10);
        check("redir10_handshake_valid", s_valid, 1);
        step(1'b1, 1'b1, 32'h20);
        first_pc  = 32'hDEAD_BEEF;
        saw_stale = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, '0);
            if (s_valid && s_pc == 32'h10) saw_stale = 1'b1;
            if (s_valid && first_pc == 32'hDEAD_BEEF) first_pc = s_pc;
        end
        check("redir20_first_pc",  first_pc,  32'h20);
        check("redir20_no_target10", saw_stale, 0);

        // PC wraps past the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFE);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, '0);
            if (s_valid) wrap_seq.push_back(s_pc);
        end
        check("wrap_len_ge3", wrap_seq.size() >= 3, 1);
        if (wrap_seq.size() >= 3) begin
            check("wrap_pc0", wrap_seq[0], 32'hFFFF_FFFE);
            check("wrap_pc1", wrap_seq[1], 32'hFFFF_FFFF);
            check("wrap_pc2", wrap_seq[2], 32'h0000_0000);
        end

        // Reset mid-stream with a read in flight.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0);
        apply_reset(1);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, '0);

        // Random traffic: sporadic stalls and redirects, some back-to-back or near the wrap point.
        for (int k = 0; k < 400; k++) begin
            bit          rdy;
            bit          redir;
            logic [31:0] tgt;
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom();
            step(rdy, redir, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL use parameter size, default 32, as the width of instruction, PC and data.
REQ-002 The block SHALL use parameter DEPTH, default 4, as the number of prefetch queue entries; legal values are 2, 4 or 8.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is the reset: asynchronous, active-low; the block is held in reset while it is 0.
REQ-005 Port redirect  input  1  SHALL request a flush and a PC change (taken branch, call or return).
REQ-006 Port redirect_pc  input  size  is the new fetch PC, sampled when redirect=1.
REQ-007 Port imem_en  output  1  is the instruction-memory read strobe.
REQ-008 Port imem_addr  output  size  is the word address presented to instruction memory.
REQ-009 Port imem_data  input  size  is the instruction word, valid exactly one cycle after imem_en=1 (synchronous memory).
REQ-010 Port out_valid  output  1  indicates the queue head is valid.
REQ-011 Port out_ready  input  1  indicates decode accepts the head.
REQ-012 Port out_instr  output  size  is the head instruction word.
REQ-013 Port out_pc  output  size  is the PC of the head instruction.
REQ-014 Port out_pc_4  output  size  is out_pc+1 (word addressing).
REQ-015 Port count  output  4  is the number of occupied queue entries.

Function
REQ-016 The FSM SHALL have states BOOT, FETCH and HOLD; reset enters BOOT, and BOOT moves to FETCH after one cycle with imem_en=0.
REQ-017 In FETCH, imem_en SHALL be 1 when (count + inflight) < DEPTH and redirect=0; otherwise the FSM SHALL go to HOLD with imem_en=0.
REQ-018 HOLD SHALL return to FETCH in the first cycle the credit condition of REQ-017 holds again.
REQ-019 imem_addr SHALL equal the fetch_pc register.
REQ-020 fetch_pc SHALL increment by 1 on each issued read and SHALL wrap from 0xFFFFFFFF to 0x00000000.
REQ-021 inflight SHALL be set on an issued read and cleared the following cycle.
REQ-022 The cycle after an issue, imem_data and the issuing PC SHALL be pushed into the queue unless that read was killed.
REQ-023 A handshake (out_valid & out_ready) SHALL pop the head.
REQ-024 Push and pop in the same cycle SHALL both occur, including when the queue is full; count is unchanged.
REQ-025 Credit accounting SHALL make overflow impossible, and the block SHALL never push when count=DEPTH without a pop.
REQ-026 out_valid SHALL be 1 iff count>0; out_instr and out_pc SHALL be driven from the head register with no combinational path from imem_data.
REQ-027 When redirect=1:
- the handshake of that cycle completes normally;
- all other entries are flushed and count becomes 0;
- any in-flight read is killed;
- fetch_pc is loaded with redirect_pc;
- imem_en is 0 that cycle.
REQ-028 After a redirect, the first issue of redirect_pc SHALL occur in cycle +1 and out_valid SHALL rise in cycle +3.
REQ-029 Back-to-back redirects SHALL each take effect; the last one wins and earlier targets are never pushed.
REQ-030 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 While reset=0, the block SHALL hold:
- state=BOOT, fetch_pc=0, inflight=0, count=0;
- imem_en=0, out_valid=0;
- imem_addr=0, out_instr=0, out_pc=0, out_pc_4=1.
REQ-032 If reset asserts mid-operation, any in-flight read SHALL be discarded and no push SHALL occur after reset deasserts.

Configuration
REQ-033 With FETCH_PERF_EN defined, the block SHALL add outputs perf_fetched (16-bit count of pushes) and perf_flushed (16-bit count of entries plus killed reads discarded by redirect). Both SHALL saturate at 0xFFFF and reset to 0.
REQ-034 Without FETCH_PERF_EN, those ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-035 Reset release with out_ready=1 and imem_data=addr: imem_en rises in cycle 1 and out_valid in cycle 3, with out_pc=0,1,2,... one per cycle and out_pc_4=out_pc+1.
REQ-036 out_ready=0 for 10 cycles: count saturates at 4, imem_en=0 (HOLD), and no entry is lost or duplicated; after out_ready=1 the PCs continue in sequence.
REQ-037 Redirect to 0x40 while count=3 and a read is in flight: count becomes 0, stale PCs never appear, and out_pc=0x40 appears 3 cycles later.
REQ-038 Redirect to 0x10 with a simultaneous handshake, then redirect to 0x20 the next cycle: the popped head is consumed, 0x10 never appears, and the first new out_pc=0x20.
REQ-039 Redirect to 0xFFFFFFFE: out_pc sequence is 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-040 With FETCH_PERF_EN, after the REQ-037 scenario perf_flushed=4; asserting reset mid-stream clears both counters and the queue.
